viz_sample_sched: RTL and testbench

- Scheduler between the audio codec read interface and the 16-bar audio visualizer shift chain (7-deep L/R registers plus live input).
- Pops codec samples, decimates them and holds one pending L/R pair.
- Advances the visualizer chain (one en pulse) only during VGA vertical blanking, with a per-frame budget, so bars never change mid-frame.
- Counts dropped samples for debug.

---
 rtl/viz_pkg.sv | 10 +
 rtl/viz_decimator.sv | 50 +++++
 rtl/viz_sample_sched.sv | 122 ++++++++++++
 tb/tb_viz_sample_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/viz_pkg.sv
// Shared types and constants for the audio visualizer sample scheduler.
package viz_pkg;

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_SHIFT} sched_state_t;

  localparam int AUDIO_DW = 24;
  localparam int NUM_BARS = 16;
  localparam int DECIM_CW = 10;

endpackage

// File: rtl/viz_decimator.sv
// Codec pop-strobe generator and 1-of-DECIM sample decimator.
module viz_decimator
  import viz_pkg::*;
#(
  parameter int DECIM = 64,
  parameter int DW    = AUDIO_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_read_ready,
  input  logic [DW-1:0] i_left,
  input  logic [DW-1:0] i_right,
  output logic          o_read,
  output logic          o_keep_valid,
  output logic [DW-1:0] o_keep_left,
  output logic [DW-1:0] o_keep_right
);

  localparam logic [DECIM_CW-1:0] LP_LAST = DECIM_CW'(DECIM - 1);

  logic                r_run;
  logic                r_read_d;
  logic [DECIM_CW-1:0] r_decim_cnt;
  logic                w_pop;
  logic                w_last;

  // r_run keeps the strobe low while reset is held and for the first edge after it
  assign w_pop  = r_run & i_read_ready & ~r_read_d;
  assign w_last = (r_decim_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_read_d    <= 1'b0;
      r_decim_cnt <= '0;
    end else begin
      r_run    <= 1'b1;
      r_read_d <= w_pop;
      if (w_pop) begin
        r_decim_cnt <= w_last ? '0 : r_decim_cnt + 1'b1;
      end
    end
  end

  assign o_read       = w_pop;
  assign o_keep_valid = w_pop & w_last;
  assign o_keep_left  = i_left;
  assign o_keep_right = i_right;

endmodule

// File: rtl/viz_sample_sched.sv
// Holds one decimated L/R pair and releases it to the visualizer chain
// only during vertical blanking, limited to a per-frame shift budget.
module viz_sample_sched
  import viz_pkg::*;
#(
  parameter int DECIM            = 64,
  parameter int SHIFTS_PER_FRAME = 2,
  parameter int DW               = AUDIO_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          read_ready,
  input  logic [DW-1:0] readdata_left,
  input  logic [DW-1:0] readdata_right,
  output logic          read,
  input  logic          vblank,
  input  logic          freeze,
  output logic [DW-1:0] dataL,
  output logic [DW-1:0] dataR,
  output logic          en,
  output logic [15:0]   drop_cnt,
  output logic          pending
);

  localparam logic [3:0] LP_BUDGET = 4'(SHIFTS_PER_FRAME);

  sched_state_t  r_state;
  sched_state_t  w_next;
  logic [3:0]    r_budget;
  logic          r_vblank_d;
  logic          r_freeze;
  logic [DW-1:0] r_dataL;
  logic [DW-1:0] r_dataR;
  logic [15:0]   r_drop_cnt;

  logic          w_keep;
  logic [DW-1:0] w_keep_left;
  logic [DW-1:0] w_keep_right;
  logic          w_vb_rise;

  viz_decimator #(
    .DECIM (DECIM),
    .DW    (DW)
  ) u_decim (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read_ready (read_ready),
    .i_left       (readdata_left),
    .i_right      (readdata_right),
    .o_read       (read),
    .o_keep_valid (w_keep),
    .o_keep_left  (w_keep_left),
    .o_keep_right (w_keep_right)
  );

  assign w_vb_rise = vblank & ~r_vblank_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // freeze is taken through a register, so a release shows up as en two cycles later
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: if (w_keep) w_next = S_HOLD;
      S_HOLD:  if (vblank && (r_budget != '0) && !r_freeze) w_next = S_SHIFT;
      S_SHIFT: w_next = w_keep ? S_HOLD : S_EMPTY;
      default: w_next = S_EMPTY;
    endcase
  end

  always_comb begin
    en      = 1'b0;
    pending = 1'b0;
    case (r_state)
      S_HOLD:  pending = 1'b1;
      S_SHIFT: en      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblank_d <= 1'b0;
      r_freeze   <= 1'b0;
      r_budget   <= LP_BUDGET;
    end else begin
      r_vblank_d <= vblank;
      r_freeze   <= freeze;
      if (w_vb_rise) begin
        r_budget <= LP_BUDGET;
      end else if (en && (r_budget != '0)) begin
        r_budget <= r_budget - 1'b1;
      end
    end
  end

  // A latch only ever lands on the edge closing a cycle, so data is stable through en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dataL    <= '0;
      r_dataR    <= '0;
      r_drop_cnt <= '0;
    end else if (w_keep) begin
      r_dataL <= w_keep_left;
      r_dataR <= w_keep_right;
      if ((r_state == S_HOLD) && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign dataL    = r_dataL;
  assign dataR    = r_dataR;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_viz_sample_sched.sv
// Directed bench for viz_sample_sched with DECIM=4, SHIFTS_PER_FRAME=2.
module tb_viz_sample_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_ready;
  logic [23:0] readdata_left;
  logic [23:0] readdata_right;
  logic        read;
  logic        vblank;
  logic        freeze;
  logic [23:0] dataL;
  logic [23:0] dataR;
  logic        en;
  logic [15:0] drop_cnt;
  logic        pending;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int base     = 0;
  int smp      = 1;

  viz_sample_sched #(
    .DECIM            (4),
    .SHIFTS_PER_FRAME (2),
    .DW               (24)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_ready     (read_ready),
    .readdata_left  (readdata_left),
    .readdata_right (readdata_right),
    .read           (read),
    .vblank         (vblank),
    .freeze         (freeze),
    .dataL          (dataL),
    .dataR          (dataR),
    .en             (en),
    .drop_cnt       (drop_cnt),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Codec model: sample n presents L=n*100, R=n*100+1; a pop advances to the next
  always @(posedge clk) if (read) smp <= smp + 1;
  assign readdata_left  = 24'(smp * 100);
  assign readdata_right = 24'(smp * 100 + 1);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc - base);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while ((cyc - base) < n) tick();
  endtask

  int          en_n;
  int          en_overlap;
  logic        prev_en;
  logic [23:0] en_data0;
  logic [23:0] en_data1;
  int          found;

  initial begin
    rst_n      = 1'b0;
    read_ready = 1'b0;
    vblank     = 1'b0;
    freeze     = 1'b0;
    tick(); tick(); tick();
    check_eq("rst_read",    32'(read),     32'd0);
    check_eq("rst_en",      32'(en),       32'd0);
    check_eq("rst_pending", 32'(pending),  32'd0);
    check_eq("rst_drop",    32'(drop_cnt), 32'd0);
    check_eq("rst_dataL",   32'(dataL),    32'd0);

    base       = cyc;
    rst_n      = 1'b1;
    read_ready = 1'b1;

    // Pop strobe alternates; pops land on odd cycles, every 4th pop is kept
    goto(1); check_eq("read_c1", 32'(read), 32'd1);
    goto(2); check_eq("read_c2", 32'(read), 32'd0);
    goto(3); check_eq("read_c3", 32'(read), 32'd1);
    goto(4); check_eq("read_c4", 32'(read), 32'd0);
    goto(8);
    check_eq("keep1_pending", 32'(pending),  32'd1);
    check_eq("keep1_en",      32'(en),       32'd0);
    check_eq("keep1_dataL",   32'(dataL),    32'd400);
    check_eq("keep1_dataR",   32'(dataR),    32'd401);
    check_eq("keep1_drop",    32'(drop_cnt), 32'd0);
    goto(16);
    check_eq("keep2_dataL",   32'(dataL),    32'd800);
    check_eq("keep2_drop",    32'(drop_cnt), 32'd1);
    check_eq("keep2_pending", 32'(pending),  32'd1);

    // Blank window: budget of 2 shifts, kept pairs keep arriving
    goto(17);
    vblank     = 1'b1;
    en_n       = 0;
    en_overlap = 0;
    prev_en    = 1'b0;
    en_data0   = '0;
    en_data1   = '0;
    for (int i = 0; i < 25; i++) begin
      if (en) begin
        if (en_n == 0) en_data0 = dataL;
        if (en_n == 1) en_data1 = dataL;
        en_n++;
        if (prev_en) en_overlap++;
      end
      prev_en = en;
      tick();
    end
    check_eq("blank_en_count", 32'(en_n),       32'd2);
    check_eq("blank_en_width", 32'(en_overlap), 32'd0);
    check_eq("blank_en_data0", 32'(en_data0),   32'd800);
    check_eq("blank_en_data1", 32'(en_data1),   32'd1200);
    check_eq("after_blank_pending", 32'(pending),  32'd1);
    check_eq("after_blank_dataL",   32'(dataL),    32'd2000);
    check_eq("after_blank_drop",    32'(drop_cnt), 32'd2);
    check_eq("after_blank_en",      32'(en),       32'd0);
    vblank = 1'b0;

    // Next rising edge reloads the budget and releases the held pair
    goto(43);
    vblank = 1'b1;
    found  = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      if (en) found = 1;
      else tick();
    end
    check_eq("rise2_en_seen",  32'(found),      32'd1);
    check_eq("rise2_en_cycle", 32'(cyc - base), 32'd45);
    check_eq("rise2_en_dataL", 32'(dataL),      32'd2000);
    vblank = 1'b0;

    // Freeze holds the pair through a blank; drops still count
    goto(48);
    check_eq("pre_freeze_pending", 32'(pending), 32'd1);
    check_eq("pre_freeze_dataL",   32'(dataL),   32'd2400);
    freeze = 1'b1;
    goto(50);
    vblank = 1'b1;
    en_n   = 0;
    for (int i = 0; i < 10; i++) begin
      if (en) en_n++;
      tick();
    end
    check_eq("freeze_no_en",   32'(en_n),     32'd0);
    check_eq("freeze_pending", 32'(pending),  32'd1);
    check_eq("freeze_dataL",   32'(dataL),    32'd2800);
    check_eq("freeze_drop",    32'(drop_cnt), 32'd3);
    freeze = 1'b0;
    goto(61); check_eq("unfreeze_c1_en", 32'(en), 32'd0);
    goto(62);
    check_eq("unfreeze_c2_en",    32'(en),    32'd1);
    check_eq("unfreeze_c2_dataL", 32'(dataL), 32'd2800);
    goto(65);
    check_eq("shift3200_en",    32'(en),    32'd1);
    check_eq("shift3200_dataL", 32'(dataL), 32'd3200);
    vblank = 1'b0;

    // Kept pair lands in the shift cycle itself
    goto(77);
    vblank = 1'b1;
    goto(78); check_eq("sh_c78_en", 32'(en), 32'd0);
    goto(79);
    check_eq("sh_en",    32'(en),       32'd1);
    check_eq("sh_dataL", 32'(dataL),    32'd3600);
    check_eq("sh_drop",  32'(drop_cnt), 32'd3);
    goto(80);
    check_eq("sh_next_en",      32'(en),       32'd0);
    check_eq("sh_next_pending", 32'(pending),  32'd1);
    check_eq("sh_next_dataL",   32'(dataL),    32'd4000);
    check_eq("sh_next_dataR",   32'(dataR),    32'd4001);
    check_eq("sh_next_drop",    32'(drop_cnt), 32'd3);
    goto(81);
    vblank = 1'b0;

    // Saturation: preload the counter near its limit, then keep overwriting
    goto(96);
    check_eq("presat_drop", 32'(drop_cnt), 32'd4);
    force dut.r_drop_cnt = 16'hFFFD;
    goto(97);
    release dut.r_drop_cnt;
    goto(104); check_eq("sat_fffe",  32'(drop_cnt), 32'h0000FFFE);
    goto(112); check_eq("sat_ffff",  32'(drop_cnt), 32'h0000FFFF);
    goto(120); check_eq("sat_hold1", 32'(drop_cnt), 32'h0000FFFF);
    goto(128);
    check_eq("sat_hold2", 32'(drop_cnt), 32'h0000FFFF);
    check_eq("sat_dataL", 32'(dataL),    32'd6400);

    // Asynchronous reset in the middle of an en/read cycle
    goto(129);
    vblank = 1'b1;
    goto(131);
    check_eq("prerst_en",   32'(en),   32'd1);
    check_eq("prerst_read", 32'(read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_en",      32'(en),       32'd0);
    check_eq("arst_read",    32'(read),     32'd0);
    check_eq("arst_pending", 32'(pending),  32'd0);
    check_eq("arst_drop",    32'(drop_cnt), 32'd0);
    check_eq("arst_dataL",   32'(dataL),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
